// File: rtl/datareq_sched_pkg.sv
// Shared types and helpers for the data-request scheduler: FSM state codes, the
// request record and the saturating gate-length calculation.
package datareq_sched_pkg;

   localparam int unsigned GATE_W    = 16;
   localparam int unsigned MAX_TAG_W = 16;
   localparam int unsigned MAX_PKT_W = 16;

   typedef logic [1:0] state_t;
   localparam state_t StIdle     = 2'd0;
   localparam state_t StDelay    = 2'd1;
   localparam state_t StGate     = 2'd2;
   localparam state_t StWaitDone = 2'd3;

   typedef struct packed {
      logic [MAX_TAG_W-1:0] tag;
      logic [MAX_PKT_W-1:0] npkt;
   } req_t;

   // Computed wide so large packet counts clamp to the gate counter range.
   function automatic logic [GATE_W-1:0] gate_len(input logic [MAX_PKT_W-1:0] npkt,
                                                  input int unsigned offset,
                                                  input int unsigned cyc_per_pkt);
      logic [63:0] g;
      g = 64'(offset) + 64'(cyc_per_pkt) * 64'(npkt);
      return (g > 64'((1 << GATE_W) - 1)) ? '1 : g[GATE_W-1:0];
   endfunction

endpackage

// File: rtl/datareq_scheduler_if.sv
// Request and command-handler signals of the data-request scheduler.
// master: request source / command handler side; slave: the scheduler.
interface datareq_scheduler_if #(
   parameter int unsigned TAG_W = 8,
   parameter int unsigned PKT_W = 10
);
   logic             req_valid;
   logic [TAG_W-1:0] req_tag;
   logic [PKT_W-1:0] req_npkt;
   logic             req_ready;
   logic             xfer_done;
   logic             data_ready;
   logic [TAG_W-1:0] cur_tag;
   logic [PKT_W-1:0] cur_npkt;

   modport master (
      output req_valid, req_tag, req_npkt, xfer_done,
      input  req_ready, data_ready, cur_tag, cur_npkt
   );

   modport slave (
      input  req_valid, req_tag, req_npkt, xfer_done,
      output req_ready, data_ready, cur_tag, cur_npkt
   );
endinterface

// File: rtl/datareq_fifo.sv
// Synchronous request FIFO with registered occupancy; pushes while full and pops
// while empty are ignored.
module datareq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 18
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == (AW + 1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW + 1)'(1);
            2'b01:   level_q <= level_q - (AW + 1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/datareq_scheduler.sv
// Sequences queued data requests onto the DATAREQ_DATA_READY gate, one at a time.
// Optional WAIT_DONE watchdog enabled by defining DATAREQ_TIMEOUT_EN.
module datareq_scheduler
   import datareq_sched_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TAG_W       = 8,
   parameter int unsigned PKT_W       = 10,
   parameter int unsigned DELAY_CNT   = 4,
   parameter int unsigned OFFSET      = 4,
   parameter int unsigned CYC_PER_PKT = 14,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   datareq_scheduler_if.slave     bus,
   input  logic                   clr_flags,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] q_level,
   output logic                   overflow,
   output logic                   timeout
);
   localparam int unsigned QW = TAG_W + PKT_W;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W > MAX_TAG_W ||
       PKT_W > MAX_PKT_W || TIMEOUT_CYC == 0) begin : g_param_check
      $error("datareq_scheduler: unsupported parameter set");
   end

   state_t            state_q, state_d;
   logic [GATE_W-1:0] cnt_q, cnt_d, gate_len_q;
   logic              dr_q, dr_d, overflow_q;
   logic              fifo_full, fifo_empty, pop, drop, expire;
   logic [QW-1:0]     fifo_rdata;
   req_t              head, cur_q;

   assign pop  = (state_q == StIdle) && !fifo_empty;
   assign drop = bus.req_valid && fifo_full;
   assign head = {MAX_TAG_W'(fifo_rdata[QW-1:PKT_W]), MAX_PKT_W'(fifo_rdata[PKT_W-1:0])};

   datareq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (QW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.req_valid),
      .pop   (pop),
      .wdata ({bus.req_tag, bus.req_npkt}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (q_level)
   );

`ifdef DATAREQ_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q;

   // A completion on the expiry cycle wins, so expiry requires xfer_done low.
   assign expire = (state_q == StWaitDone) && !bus.xfer_done &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign wd_d   = ((state_q == StWaitDone) && !bus.xfer_done && !expire) ?
                   wd_q + WD_W'(1) : '0;
   assign timeout = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         if (expire)         timeout_q <= 1'b1;
         else if (clr_flags) timeout_q <= 1'b0;
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               cnt_d   = '0;
               state_d = (DELAY_CNT == 0) ? StGate : StDelay;
            end
         end
         StDelay: begin
            if (cnt_q == GATE_W'(DELAY_CNT - 1)) begin
               cnt_d   = '0;
               state_d = StGate;
            end else begin
               cnt_d = cnt_q + GATE_W'(1);
            end
         end
         // data_ready is registered, so GATE spans G+1 cycles to cover its last high cycle.
         StGate: begin
            if (cnt_q == gate_len_q) begin
               state_d = StWaitDone;
            end else begin
               dr_d  = 1'b1;
               cnt_d = cnt_q + GATE_W'(1);
            end
         end
         StWaitDone: begin
            if (bus.xfer_done || expire) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         dr_q       <= 1'b0;
         gate_len_q <= '0;
         cur_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dr_q    <= dr_d;
         if (pop) begin
            cur_q      <= head;
            gate_len_q <= gate_len(head.npkt, OFFSET, CYC_PER_PKT);
         end
         if (drop)           overflow_q <= 1'b1;
         else if (clr_flags) overflow_q <= 1'b0;
      end
   end

   assign bus.req_ready  = !fifo_full;
   assign bus.data_ready = dr_q;
   assign bus.cur_tag    = cur_q.tag[TAG_W-1:0];
   assign bus.cur_npkt   = cur_q.npkt[PKT_W-1:0];
   assign busy           = (state_q != StIdle);
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_datareq_scheduler.sv
// Self-checking bench for datareq_scheduler: a default build (DELAY_CNT=4) and a
// DELAY_CNT=0 / TIMEOUT_CYC=16 build; watchdog cases run when DATAREQ_TIMEOUT_EN is set.
module tb_datareq_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr_a, clr_b, busy_a, busy_b, overflow_a, overflow_b, timeout_a, timeout_b;
   logic [2:0] q_level_a, q_level_b;
   int         checks = 0;
   int         failures = 0;

   datareq_scheduler_if #(.TAG_W(8), .PKT_W(10)) bus_a ();
   datareq_scheduler_if #(.TAG_W(8), .PKT_W(10)) bus_b ();

   datareq_scheduler #(
      .DEPTH(4), .TAG_W(8), .PKT_W(10), .DELAY_CNT(4), .OFFSET(4), .CYC_PER_PKT(14),
      .TIMEOUT_CYC(4096)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_flags(clr_a), .busy(busy_a),
      .q_level(q_level_a), .overflow(overflow_a), .timeout(timeout_a)
   );

   datareq_scheduler #(
      .DEPTH(4), .TAG_W(8), .PKT_W(10), .DELAY_CNT(0), .OFFSET(4), .CYC_PER_PKT(14),
      .TIMEOUT_CYC(16)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_flags(clr_b), .busy(busy_b),
      .q_level(q_level_b), .overflow(overflow_b), .timeout(timeout_b)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "bench time limit");
   end

   typedef struct {
      logic [7:0] tag;
      logic [9:0] npkt;
   } req_rec_t;

   typedef struct {
      logic [7:0] tag;
      logic [9:0] npkt;
      int         first;
      int         width;
   } vec_t;

   // Reference: gate length straight from OFFSET + CYC_PER_PKT * npkt, clamped to 16 bits.
   function automatic int exp_gate(input int npkt);
      int g;
      g = 4 + 14 * npkt;
      return (g > 65535) ? 65535 : g;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic dr(input bit b);
      return b ? bus_b.data_ready : bus_a.data_ready;
   endfunction

   task automatic push(input bit b, input logic [7:0] tag, input logic [9:0] npkt);
      if (b) begin
         bus_b.req_valid = 1'b1; bus_b.req_tag = tag; bus_b.req_npkt = npkt;
      end else begin
         bus_a.req_valid = 1'b1; bus_a.req_tag = tag; bus_a.req_npkt = npkt;
      end
      tick();
      bus_a.req_valid = 1'b0;
      bus_b.req_valid = 1'b0;
   endtask

   task automatic done(input bit b);
      if (b) bus_b.xfer_done = 1'b1; else bus_a.xfer_done = 1'b1;
      tick();
      bus_a.xfer_done = 1'b0;
      bus_b.xfer_done = 1'b0;
   endtask

   // first: cycles from the call to the first data_ready=1 sample; width: high cycles.
   task automatic measure(input bit b, output int first, output int width);
      first = -1;
      width = 0;
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (dr(b)) begin
            first = k;
            break;
         end
      end
      if (first < 0) begin
         checks++;
         failures++;
         $display("FAIL gate_rise_bound: no data_ready within 400 cycles, required a gate");
         return;
      end
      width = 1;
      for (int k = 0; k < 70000; k++) begin
         tick();
         if (!dr(b)) break;
         width++;
      end
   endtask

   initial begin
      vec_t     vecs[4];
      req_rec_t model[$];
      req_rec_t r;
      int       first, width, n;

      vecs[0] = '{8'h2A, 10'd3, 6, 46};
      vecs[1] = '{8'h11, 10'd1, 6, 18};
      vecs[2] = '{8'h7F, 10'd10, 6, 144};
      vecs[3] = '{8'hC3, 10'd0, 6, 4};

      bus_a.req_valid = 1'b0; bus_a.req_tag = '0; bus_a.req_npkt = '0; bus_a.xfer_done = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_tag = '0; bus_b.req_npkt = '0; bus_b.xfer_done = 1'b0;
      clr_a = 1'b0;
      clr_b = 1'b0;
      repeat (3) tick();

      chk("rst_data_ready", bus_a.data_ready, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_q_level", q_level_a, 0);
      chk("rst_req_ready", bus_a.req_ready, 1);
      chk("rst_overflow", overflow_a, 0);
      chk("rst_timeout", timeout_a, 0);
      chk("rst_cur_tag", bus_a.cur_tag, 0);
      chk("rst_cur_npkt", bus_a.cur_npkt, 0);
      chk("rst_b_req_ready", bus_b.req_ready, 1);
      #2 rst_n = 1'b1;
      tick();

      // Single requests through the default build.
      foreach (vecs[i]) begin
         push(1'b0, vecs[i].tag, vecs[i].npkt);
         measure(1'b0, first, width);
         chk("vec_first", first, vecs[i].first);
         chk("vec_width", width, vecs[i].width);
         chk("vec_cur_tag", bus_a.cur_tag, vecs[i].tag);
         chk("vec_cur_npkt", bus_a.cur_npkt, vecs[i].npkt);
         chk("vec_busy_wait", busy_a, 1);
         tick();
         done(1'b0);
         chk("vec_busy_after_done", busy_a, 0);
      end

      // Stall in WAIT_DONE, then fill the queue and overflow it.
      push(1'b0, 8'h3C, 10'd0);
      measure(1'b0, first, width);
      chk("stall_width", width, 4);
      repeat (30) tick();
      chk("stall_busy", busy_a, 1);
      chk("stall_data_ready", bus_a.data_ready, 0);
      for (int i = 0; i < 5; i++) push(1'b0, 8'(16 + i), 10'(i + 1));
      chk("full_overflow", overflow_a, 1);
      chk("full_q_level", q_level_a, 4);
      chk("full_req_ready", bus_a.req_ready, 0);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("clr_overflow", overflow_a, 0);
      clr_a = 1'b1;
      push(1'b0, 8'hEE, 10'd9);
      clr_a = 1'b0;
      chk("set_beats_clear", overflow_a, 1);
      chk("drop_q_level", q_level_a, 4);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("clr_overflow2", overflow_a, 0);
      done(1'b0);
      for (int i = 0; i < 4; i++) begin
         measure(1'b0, first, width);
         chk("order_tag", bus_a.cur_tag, 8'(16 + i));
         chk("order_width", width, exp_gate(i + 1));
         done(1'b0);
      end
      chk("drained_q_level", q_level_a, 0);

      // DELAY_CNT=0 build, including the largest packet count.
      push(1'b1, 8'h55, 10'd1023);
      measure(1'b1, first, width);
      chk("d0_first", first, 2);
      chk("d0_width_1023", width, 14326);
      chk("d0_cur_tag", bus_b.cur_tag, 8'h55);
      done(1'b1);
      push(1'b1, 8'h66, 10'd2);
      measure(1'b1, first, width);
      chk("d0_first2", first, 2);
      chk("d0_width2", width, 32);
      done(1'b1);

      // Asynchronous reset in the middle of a gate with one request still queued.
      push(1'b0, 8'hA1, 10'd5);
      push(1'b0, 8'hA2, 10'd6);
      repeat (10) tick();
      chk("mid_gate_dr", bus_a.data_ready, 1);
      chk("mid_gate_q_level", q_level_a, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data_ready", bus_a.data_ready, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_q_level", q_level_a, 0);
      #2 rst_n = 1'b1;
      tick();
      push(1'b0, 8'hB5, 10'd2);
      measure(1'b0, first, width);
      chk("post_rst_first", first, 6);
      chk("post_rst_width", width, 32);
      chk("post_rst_tag", bus_a.cur_tag, 8'hB5);
      done(1'b0);

      // Random bursts against the in-order queue model.
      for (int round = 0; round < 6; round++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            r.tag  = 8'($urandom);
            r.npkt = 10'($urandom_range(0, 20));
            model.push_back(r);
            push(1'b0, r.tag, r.npkt);
         end
         for (int i = 0; i < n; i++) begin
            measure(1'b0, first, width);
            r = model.pop_front();
            chk("rand_tag", bus_a.cur_tag, r.tag);
            chk("rand_npkt", bus_a.cur_npkt, r.npkt);
            chk("rand_width", width, exp_gate(int'(r.npkt)));
            repeat ($urandom_range(0, 3)) tick();
            done(1'b0);
         end
      end
      chk("rand_overflow", overflow_a, 0);

`ifdef DATAREQ_TIMEOUT_EN
      push(1'b1, 8'hE1, 10'd0);
      push(1'b1, 8'hE2, 10'd1);
      measure(1'b1, first, width);
      chk("to_width", width, 4);
      repeat (15) tick();
      chk("to_not_yet", timeout_b, 0);
      chk("to_busy_15", busy_b, 1);
      tick();
      chk("to_set", timeout_b, 1);
      measure(1'b1, first, width);
      chk("to_next_tag", bus_b.cur_tag, 8'hE2);
      chk("to_next_width", width, 18);
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      chk("to_clr", timeout_b, 0);
      repeat (14) tick();
      done(1'b1);
      chk("to_done_at_expiry", timeout_b, 0);
      chk("to_done_busy", busy_b, 0);
`else
      push(1'b1, 8'hE1, 10'd0);
      measure(1'b1, first, width);
      chk("nto_width", width, 4);
      repeat (40) tick();
      chk("nto_timeout", timeout_b, 0);
      chk("nto_busy", busy_b, 1);
      done(1'b1);
      chk("nto_busy_done", busy_b, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
